canny_frame_packer: RTL and testbench
=====================================

Name: canny_frame_packer

Overview:
- Sits directly upstream of uart_tx_fifo and is the only writer of its push/tx_data interface.
- Captures one full Canny edge frame arriving at pixel rate (canny_de/canny_r, one pixel per clk).
- Thresholds each pixel to one bit, packs 8 pixels per byte into an internal frame RAM, then replays the frame into uart_tx_fifo.
- The replay is prefixed by a 2-byte sync header and throttled by tx_fifo_full, so bursts faster than UART rate never overflow the FIFO.

Parameters:
- FRAME_PIX, 40800: pixels per frame; must be a multiple of 8.
- THRESH, 128: canny_r >= THRESH packs as bit 1, otherwise 0.
- HDR0, 8'hAA: first sync header byte.
- HDR1, 8'h55: second sync header byte.
- Derived localparams: BYTES = FRAME_PIX/8 (5100 at default); ADDR_W = $clog2(BYTES).

Ports:
- clk  in  1  system clock, 100 MHz
- reset  in  1  asynchronous, active-low (0 = in reset); deassertion is synchronous to clk
- canny_de  in  1  pixel valid strobe
- canny_r  in  8  pixel value
- tx_fifo_full  in  1  from uart_tx_fifo
- tx_data  out  8  byte to uart_tx_fifo
- push  out  1  one-cycle write strobe to uart_tx_fifo
- busy  out  1  high in any state other than IDLE
- frame_done  out  1  one-cycle pulse after the last frame byte is pushed
- overflow  out  1  sticky; set when canny_de=1 is seen during a readout state; cleared only by reset

Behaviour:
- Reset (reset=0, asynchronous):
  - Outputs: push=0, tx_data=0, busy=0, frame_done=0, overflow=0.
  - Internal: state=IDLE, pixel counter=0, byte counter=0, shift register=0.
  - RAM contents are don't-care.
- FSM states: IDLE, CAPTURE, HDR0, HDR1, RD, RDW, SEND, DONE.
- IDLE: the first canny_de=1 is accepted as pixel 0 in that same cycle and moves the FSM to CAPTURE.
- CAPTURE:
  - Each canny_de=1 cycle accepts one pixel; gaps (de=0) are allowed and do not advance the counter.
  - Pixel index i sets bit 7-(i mod 8), i.e. MSB first.
  - On the 8th pixel of a group, the packed byte (including the current pixel) is written to RAM address i/8 on the next clk edge.
  - After the write of address BYTES-1, go to HDR0.
- Readout states (HDR0, HDR1, RD, RDW, SEND, DONE): any canny_de=1 is ignored and sets overflow.
- HDR0 / HDR1:
  - Each state presents its header byte on tx_data.
  - push=1 in the first cycle where tx_fifo_full=0, then the FSM advances (HDR0 -> HDR1, HDR1 -> RD).
- RD: drive RAM read address = byte counter; go to RDW.
- RDW: the RAM has 1-cycle synchronous read latency; register the data into tx_data; go to SEND.
- SEND:
  - Hold tx_data stable.
  - push=1 in exactly one cycle, the first with tx_fifo_full=0.
  - If byte counter = BYTES-1, go to DONE; otherwise increment the counter and go to RD.
- DONE: frame_done=1 for one cycle; clear the counters; go to IDLE.
- Push rules:
  - push is never asserted while tx_fifo_full=1 in the same cycle.
  - Every byte is pushed exactly once (no loss, no duplication).
  - Minimum spacing is 3 cycles per data byte.
- Frame totals: push count is exactly BYTES+2 (5102 at default).
- Reset mid-operation: the frame in progress is abandoned. After reset release, the next de=1 starts a new frame at address 0.
- A frame received after DONE (state IDLE) is captured normally. A pixel arriving in the DONE cycle itself is dropped and sets overflow.

Decomposition:
- Package canny_tx_pkg:
  - state enum type.
  - Default header constants HDR0/HDR1.
  - Default FRAME_PIX.
- Sub-module frame_bram:
  - Simple dual-port RAM, BYTES x 8.
  - Write port: we/waddr/wdata.
  - Read port: raddr, registered dout, 1-cycle latency.
  - Inferable as block RAM.
- Top-level RTL: about 200 lines; frame_bram: about 30 lines.

Test Plan:
1. Reset check: hold reset=0 and drive canny_de=1 -> push=0, busy=0, overflow=0, tx_data=0 throughout. After release, the first de=1 puts busy high on the next cycle.
2. Full frame, FRAME_PIX=40800, canny_r=8'hFF every cycle, tx_fifo_full=0:
   - pushes are 8'hAA, 8'h55, then 5100 x 8'hFF (5102 total);
   - exactly one frame_done pulse, after the last push.
3. Threshold and packing, FRAME_PIX=64, pixel pattern {8'h80, 8'h7F, 0, 0, 0, 0, 0, 8'hFF} repeated, de gapped every other cycle -> 8 data bytes of 8'h81.
4. Backpressure: tx_fifo_full=1 for 200 cycles starting while tx_data=byte 3 in SEND -> push=0 throughout; the same byte is pushed once after full drops; the byte sequence stays intact.
5. Overflow: a second burst of canny_de=1 during readout -> overflow=1 and stays 1; the readout byte stream is unchanged. A frame sent after frame_done is captured and replayed correctly.
6. Reset mid-readout, asserted after 10 data pushes -> all outputs return to reset values immediately. A new FRAME_PIX=64 frame then yields a header plus 8 correct bytes from address 0.

Source files
------------

// File: rtl/canny_tx_pkg.sv
// Purpose: shared types and default constants for the Canny frame packer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package canny_tx_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CAPTURE,
        S_HDR0,
        S_HDR1,
        S_RD,
        S_RDW,
        S_SEND,
        S_DONE
    } state_e;

    localparam int         DEF_FRAME_PIX = 40800;
    localparam logic [7:0] DEF_HDR0      = 8'hAA;
    localparam logic [7:0] DEF_HDR1      = 8'h55;

endpackage

// File: rtl/frame_bram.sv
// Purpose: simple dual-port byte RAM holding one packed edge frame.
// Latency: 1 cycle from raddr to dout (registered read).
// Backpressure: none; one write and one read per cycle.
// Ports: we/waddr/wdata write port; raddr/dout read port.
module frame_bram #(
    parameter int DEPTH  = 5100,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [7:0]        wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [7:0]        dout
);

    logic [7:0] mem [DEPTH];

    // No reset on the array or the read register so it maps onto block RAM.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        dout <= mem[raddr];
    end

endmodule

// File: rtl/canny_frame_packer.sv
// Purpose: capture one thresholded Canny frame (8 px/byte) and replay it, sync-header first, into the UART TX FIFO.
// Latency: replay starts right after the last byte is stored; 3 cycles minimum per data byte.
// Backpressure: tx_fifo_full stalls header/data presentation; push never fires while full.
// Ports: clk, reset (async active-low); canny_de/canny_r pixel input; tx_fifo_full in;
//        tx_data/push FIFO write side; busy, frame_done (pulse), overflow (sticky) status.
module canny_frame_packer
    import canny_tx_pkg::*;
#(
    parameter int         FRAME_PIX = DEF_FRAME_PIX,
    parameter logic [7:0] THRESH    = 8'd128,
    parameter logic [7:0] HDR0      = DEF_HDR0,
    parameter logic [7:0] HDR1      = DEF_HDR1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       canny_de,
    input  logic [7:0] canny_r,
    input  logic       tx_fifo_full,
    output logic [7:0] tx_data,
    output logic       push,
    output logic       busy,
    output logic       frame_done,
    output logic       overflow
);

    localparam int                BYTES  = FRAME_PIX / 8;
    localparam int                ADDR_W = $clog2(BYTES);
    localparam logic [ADDR_W-1:0] LAST   = ADDR_W'(BYTES - 1);

    state_e            state_q, state_d;
    logic [2:0]        pix_q, pix_d;
    logic [ADDR_W-1:0] byte_q, byte_d;
    logic [7:0]        sr_q, sr_d;
    logic [7:0]        tx_q, tx_d;
    logic              ovf_q, ovf_d;

    logic              we;
    logic [7:0]        wdata;
    logic [7:0]        rdata;
    logic              pix_bit;
    logic              readout;

    assign pix_bit = (canny_r >= THRESH);
    assign readout = (state_q != S_IDLE) && (state_q != S_CAPTURE);

    // One counter serves as write address during capture and read address
    // during replay; the two phases never overlap.
    frame_bram #(
        .DEPTH  (BYTES),
        .ADDR_W (ADDR_W)
    ) u_bram (
        .clk   (clk),
        .we    (we),
        .waddr (byte_q),
        .wdata (wdata),
        .raddr (byte_q),
        .dout  (rdata)
    );

    always_comb begin
        state_d    = state_q;
        pix_d      = pix_q;
        byte_d     = byte_q;
        sr_d       = sr_q;
        tx_d       = tx_q;
        ovf_d      = ovf_q | (canny_de & readout);
        we         = 1'b0;
        push       = 1'b0;
        frame_done = 1'b0;
        tx_data    = tx_q;
        // Packed byte including the current pixel, MSB = first pixel of the group.
        wdata      = sr_q | (pix_bit ? (8'h80 >> pix_q) : 8'h00);

        case (state_q)
            S_IDLE, S_CAPTURE: begin
                if (canny_de) begin
                    pix_d   = pix_q + 3'd1;
                    sr_d    = wdata;
                    state_d = S_CAPTURE;
                    if (pix_q == 3'd7) begin
                        we   = 1'b1;
                        sr_d = 8'h00;
                        if (byte_q == LAST) begin
                            byte_d  = '0;
                            state_d = S_HDR0;
                        end else begin
                            byte_d = byte_q + ADDR_W'(1);
                        end
                    end
                end
            end
            S_HDR0: begin
                tx_data = HDR0;
                if (!tx_fifo_full) begin
                    push    = 1'b1;
                    state_d = S_HDR1;
                end
            end
            S_HDR1: begin
                tx_data = HDR1;
                if (!tx_fifo_full) begin
                    push    = 1'b1;
                    state_d = S_RD;
                end
            end
            S_RD: begin
                state_d = S_RDW;
            end
            S_RDW: begin
                tx_d    = rdata;
                state_d = S_SEND;
            end
            S_SEND: begin
                if (!tx_fifo_full) begin
                    push = 1'b1;
                    if (byte_q == LAST) begin
                        state_d = S_DONE;
                    end else begin
                        byte_d  = byte_q + ADDR_W'(1);
                        state_d = S_RD;
                    end
                end
            end
            S_DONE: begin
                frame_done = 1'b1;
                byte_d     = '0;
                pix_d      = 3'd0;
                sr_d       = 8'h00;
                state_d    = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            pix_q   <= 3'd0;
            byte_q  <= '0;
            sr_q    <= 8'h00;
            tx_q    <= 8'h00;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pix_q   <= pix_d;
            byte_q  <= byte_d;
            sr_q    <= sr_d;
            tx_q    <= tx_d;
            ovf_q   <= ovf_d;
        end
    end

    assign busy     = (state_q != S_IDLE);
    assign overflow = ovf_q;

endmodule

// File: tb/tb_canny_frame_packer.sv
// Purpose: directed self-checking bench for canny_frame_packer at three frame sizes.
// Latency: n/a.
// Backpressure: drives tx_fifo_full directly and watches every push.
module tb_canny_frame_packer;

    logic       clk = 1'b0;
    always #5 clk = ~clk;

    // Index 0: default 40800-pixel frame; 1: 64 pixels; 2: 128 pixels.
    logic       rst   [3];
    logic       de    [3];
    logic       full  [3];
    logic [7:0] r     [3];
    logic [7:0] txd   [3];
    logic       push  [3];
    logic       busy  [3];
    logic       fdone [3];
    logic       ovf   [3];

    canny_frame_packer u_big (
        .clk(clk), .reset(rst[0]), .canny_de(de[0]), .canny_r(r[0]), .tx_fifo_full(full[0]),
        .tx_data(txd[0]), .push(push[0]), .busy(busy[0]), .frame_done(fdone[0]), .overflow(ovf[0]));

    canny_frame_packer #(.FRAME_PIX(64)) u_s (
        .clk(clk), .reset(rst[1]), .canny_de(de[1]), .canny_r(r[1]), .tx_fifo_full(full[1]),
        .tx_data(txd[1]), .push(push[1]), .busy(busy[1]), .frame_done(fdone[1]), .overflow(ovf[1]));

    canny_frame_packer #(.FRAME_PIX(128)) u_m (
        .clk(clk), .reset(rst[2]), .canny_de(de[2]), .canny_r(r[2]), .tx_fifo_full(full[2]),
        .tx_data(txd[2]), .push(push[2]), .busy(busy[2]), .frame_done(fdone[2]), .overflow(ovf[2]));

    int nchk  = 0;
    int nfail = 0;
    int cyc   = 0;
    int lastp  [3];
    int fd_cnt [3];
    int fd_at  [3];
    logic [7:0] q0 [$];
    logic [7:0] q1 [$];
    logic [7:0] q2 [$];

    function automatic int qsize(input int d);
        case (d)
            0:       return q0.size();
            1:       return q1.size();
            default: return q2.size();
        endcase
    endfunction

    function automatic logic [7:0] qget(input int d, input int i);
        if (i >= qsize(d)) return 8'hxx;
        case (d)
            0:       return q0[i];
            1:       return q1[i];
            default: return q2[i];
        endcase
    endfunction

    task automatic qpush(input int d, input logic [7:0] v);
        case (d)
            0:       q0.push_back(v);
            1:       q1.push_back(v);
            default: q2.push_back(v);
        endcase
    endtask

    task automatic qclear(input int d);
        case (d)
            0:       q0.delete();
            1:       q1.delete();
            default: q2.delete();
        endcase
    endtask

    always @(posedge clk) cyc++;

    // Push log: one entry per accepted FIFO write, with full/spacing rules.
    always @(negedge clk) begin
        for (int d = 0; d < 3; d++) begin
            if (push[d] === 1'b1) begin
                nchk++;
                assert (full[d] === 1'b0) else begin
                    nfail++;
                    $error("FAIL push_while_full dut%0d observed full=%b required 0", d, full[d]);
                end
                if (qsize(d) >= 2) begin
                    nchk++;
                    assert (cyc - lastp[d] >= 3) else begin
                        nfail++;
                        $error("FAIL push_spacing dut%0d observed=%0d required>=3", d, cyc - lastp[d]);
                    end
                end
                lastp[d] = cyc;
                qpush(d, txd[d]);
            end
            if (fdone[d] === 1'b1) begin
                fd_cnt[d]++;
                fd_at[d] = qsize(d);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nchk++;
        assert (got === exp) else begin
            nfail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic wait_done(input int d, input int budget);
        int start;
        int n;
        start = fd_cnt[d];
        n = 0;
        while (fd_cnt[d] == start && n < budget) begin
            tick();
            n++;
        end
        chk($sformatf("frame_done_seen_d%0d", d), fd_cnt[d] - start, 1);
    endtask

    task automatic wait_q(input int d, input int cnt, input int budget);
        int n;
        n = 0;
        while (qsize(d) < cnt && n < budget) begin
            tick();
            n++;
        end
        chk($sformatf("push_count_reached_d%0d", d), qsize(d) >= cnt, 1);
    endtask

    // Pixel i of the frame is 128 (packs to 1, threshold boundary) when
    // bits[127-i] is set, else 127 (packs to 0).
    task automatic send_frame(input int d, input logic [127:0] bits, input int npix);
        for (int i = 0; i < npix; i++) begin
            de[d] = 1'b1;
            r[d]  = bits[127-i] ? 8'd128 : 8'd127;
            tick();
        end
        de[d] = 1'b0;
    endtask

    task automatic chk_frame(input int d, input logic [127:0] bits, input int nbytes);
        chk($sformatf("len_d%0d", d), qsize(d), nbytes + 2);
        chk($sformatf("hdr0_d%0d", d), qget(d, 0), 8'hAA);
        chk($sformatf("hdr1_d%0d", d), qget(d, 1), 8'h55);
        for (int k = 0; k < nbytes; k++) begin
            chk($sformatf("byte_d%0d_%0d", d, k), qget(d, k + 2), bits[127-8*k -: 8]);
        end
    endtask

    localparam logic [127:0] F4 = {64'h3CA5_0FF0_817E_55C3, 64'h0};
    localparam logic [127:0] F5 = {64'h0102_0408_1020_4080, 64'h0};
    localparam logic [127:0] F6 = {64'hDEAD_BEEF_0123_4567, 64'h0};
    localparam logic [127:0] F7 = 128'h0011_2233_4455_6677_8899_AABB_CCDD_EEFF;
    localparam logic [127:0] F8 = 128'hFEDC_BA98_7654_3210_0F1E_2D3C_4B5A_6978;

    initial begin
        logic [7:0] pat [8];
        logic [127:0] all81;
        int sz;
        int nff;
        pat = '{8'h80, 8'h7F, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'hFF};
        all81 = {16{8'h81}};
        for (int d = 0; d < 3; d++) begin
            rst[d] = 1'b0; de[d] = 1'b0; full[d] = 1'b0; r[d] = 8'h00;
            lastp[d] = 0; fd_cnt[d] = 0; fd_at[d] = 0;
        end

        // Reset holds outputs quiet even with pixels arriving.
        de[1] = 1'b1;
        r[1]  = 8'hFF;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("rst_push", push[1], 1'b0);
            chk("rst_busy", busy[1], 1'b0);
            chk("rst_ovf", ovf[1], 1'b0);
            chk("rst_txd", txd[1], 8'h00);
            chk("rst_fdone", fdone[1], 1'b0);
        end
        tick();
        rst[0] = 1'b1; rst[1] = 1'b1; rst[2] = 1'b1;
        de[1] = 1'b0;
        tick();

        // First pixel after release: busy rises on the following cycle.
        de[1] = 1'b1;
        r[1]  = pat[0];
        @(negedge clk);
        chk("busy_before_first_pixel", busy[1], 1'b0);
        tick();
        de[1] = 1'b0;
        @(negedge clk);
        chk("busy_after_first_pixel", busy[1], 1'b1);
        tick();

        // Threshold/packing with a gap after every pixel.
        for (int i = 1; i < 64; i++) begin
            de[1] = 1'b1;
            r[1]  = pat[i % 8];
            tick();
            de[1] = 1'b0;
            tick();
        end
        wait_done(1, 500);
        chk_frame(1, all81, 8);
        chk("pack_fd_after_last_push", fd_at[1], 10);

        // Backpressure on data byte 3 while it sits in SEND.
        qclear(1);
        send_frame(1, F4, 64);
        wait_q(1, 5, 500);
        tick();
        tick();
        full[1] = 1'b1;
        @(negedge clk);
        chk("bp_txdata_held", txd[1], 8'hF0);
        chk("bp_push_low", push[1], 1'b0);
        sz = qsize(1);
        repeat (200) tick();
        chk("bp_no_push_while_full", qsize(1), sz);
        full[1] = 1'b0;
        wait_done(1, 500);
        chk_frame(1, F4, 8);

        // Overflow: pixels during readout are dropped and latch the flag.
        qclear(1);
        send_frame(1, F5, 64);
        wait_q(1, 3, 500);
        chk("ovf_before_burst", ovf[1], 1'b0);
        de[1] = 1'b1;
        r[1]  = 8'hFF;
        repeat (20) tick();
        de[1] = 1'b0;
        @(negedge clk);
        chk("ovf_after_burst", ovf[1], 1'b1);
        wait_done(1, 500);
        chk_frame(1, F5, 8);
        qclear(1);
        send_frame(1, F6, 64);
        wait_done(1, 500);
        chk_frame(1, F6, 8);
        chk("ovf_sticky", ovf[1], 1'b1);
        chk("fd_total_small", fd_cnt[1], 4);

        // Reset mid-readout after 10 data bytes, then a clean frame.
        send_frame(2, F7, 128);
        wait_q(2, 12, 500);
        rst[2] = 1'b0;
        #1;
        chk("midrst_push", push[2], 1'b0);
        chk("midrst_busy", busy[2], 1'b0);
        chk("midrst_txd", txd[2], 8'h00);
        chk("midrst_ovf", ovf[2], 1'b0);
        chk("midrst_fdone", fdone[2], 1'b0);
        tick();
        tick();
        rst[2] = 1'b1;
        tick();
        qclear(2);
        send_frame(2, F8, 128);
        wait_done(2, 500);
        chk_frame(2, F8, 16);
        chk("midrst_fd_count", fd_cnt[2], 1);
        chk("midrst_fd_after_last", fd_at[2], 18);

        // Full-size frame of all-ones pixels.
        de[0] = 1'b1;
        r[0]  = 8'hFF;
        repeat (40800) tick();
        de[0] = 1'b0;
        wait_done(0, 20000);
        repeat (5) tick();
        chk("big_len", qsize(0), 5102);
        chk("big_hdr0", qget(0, 0), 8'hAA);
        chk("big_hdr1", qget(0, 1), 8'h55);
        nff = 0;
        for (int k = 2; k < qsize(0); k++) begin
            if (qget(0, k) == 8'hFF) nff++;
        end
        chk("big_ff_count", nff, 5100);
        chk("big_fd_count", fd_cnt[0], 1);
        chk("big_fd_after_last", fd_at[0], 5102);
        chk("big_ovf", ovf[0], 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", nchk, nfail);
        $finish;
    end

endmodule
